// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources (round robin, or fixed priority with UART_ARB_FIXED_PRIO_EN).
// Latency: req sampled -> tx_new_data next cycle -> ack on the first tx_rdy=1 edge after that.
// Backpressure: waits in IDLE/LOAD while tx_rdy=0; req must be held until ack; optional GAP_CYCLES idle bit-times after each frame.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 0,
    parameter int ID_W       = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] data,
    output logic [NUM_REQ-1:0]   ack,
    input  logic                 tx_rdy,
    output logic                 tx_new_data,
    output logic [7:0]           tx_char,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, GAP} state_t;

    state_t          state;
    logic [7:0]      gap_cnt;
    logic            drain_first;
    logic            win_vld;
    logic [ID_W-1:0] win_idx;
    logic [7:0]      win_dat;

`ifdef UART_ARB_FIXED_PRIO_EN
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_vld = 1'b1;
                win_idx = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0] last;

    // Two passes: indices above the last winner first, then wrap to the bottom.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_vld && req[i] && (i > int'(last))) begin
                win_vld = 1'b1;
                win_idx = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_vld && req[i]) begin
                win_vld = 1'b1;
                win_idx = ID_W'(i);
            end
        end
    end
`endif

    always_comb begin
        win_dat = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == win_idx) begin
                win_dat = data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tx_new_data <= 1'b0;
            tx_char     <= 8'h00;
            ack         <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
            gap_cnt     <= 8'd0;
            drain_first <= 1'b0;
`ifndef UART_ARB_FIXED_PRIO_EN
            last        <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (win_vld && tx_rdy) begin
                        state       <= LOAD;
                        tx_new_data <= 1'b1;
                        tx_char     <= win_dat;
                        busy        <= 1'b1;
                        grant_id    <= win_idx;
`ifndef UART_ARB_FIXED_PRIO_EN
                        last        <= win_idx;
`endif
                    end
                end
                LOAD: begin
                    if (tx_rdy) begin
                        tx_new_data <= 1'b0;
                        ack         <= NUM_REQ'(1) << grant_id;
                        state       <= DRAIN;
                        drain_first <= 1'b1;
                    end
                end
                DRAIN: begin
                    // tx_rdy still shows the pre-load value on the first DRAIN cycle.
                    if (drain_first) begin
                        drain_first <= 1'b0;
                    end else if (tx_rdy) begin
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= 8'(GAP_CYCLES);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt <= 8'd1) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        gap_cnt <= 8'd0;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a zero-gap instance and a GAP_CYCLES=3 instance, each fed by a 10-cycle transmitter model.
module tb_uart_tx_arbiter;

    localparam int FRAME = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] data = '0;
    logic [3:0]  ack;
    logic        tx_rdy = 1'b1;
    logic        tx_new_data;
    logic [7:0]  tx_char;
    logic        busy;
    logic [1:0]  grant_id;

    logic [3:0]  g_req = '0;
    logic [31:0] g_data = '0;
    logic [3:0]  g_ack;
    logic        g_tx_rdy = 1'b1;
    logic        g_tx_new_data;
    logic [7:0]  g_tx_char;
    logic        g_busy;
    logic [1:0]  g_grant_id;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int tx_cnt = 0;
    int g_tx_cnt = 0;
    logic hold_low = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(0), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data(data), .ack(ack),
        .tx_rdy(tx_rdy), .tx_new_data(tx_new_data), .tx_char(tx_char),
        .busy(busy), .grant_id(grant_id)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(3), .ID_W(2)) dut_gap (
        .clk(clk), .rst_n(rst_n), .req(g_req), .data(g_data), .ack(g_ack),
        .tx_rdy(g_tx_rdy), .tx_new_data(g_tx_new_data), .tx_char(g_tx_char),
        .busy(g_busy), .grant_id(g_grant_id)
    );

    // One clock step; the transmitter models load on tx_new_data && tx_rdy and stay busy FRAME cycles.
    task automatic tick();
        logic ld, gld;
        ld  = tx_new_data && tx_rdy;
        gld = g_tx_new_data && g_tx_rdy;
        @(posedge clk);
        #1;
        if (ld) tx_cnt = FRAME; else if (tx_cnt > 0) tx_cnt--;
        if (gld) g_tx_cnt = FRAME; else if (g_tx_cnt > 0) g_tx_cnt--;
        tx_rdy   = (tx_cnt == 0) && !hold_low;
        g_tx_rdy = (g_tx_cnt == 0);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (busy && t < 60) begin
            tick();
            t++;
        end
        n_vec++;
        if (busy !== 1'b0) begin
            $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, want 0", name, busy, t);
            n_err++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; tx_rdy = 1'b1;
        tick(); tick(); tick();
        n_vec++; if (tx_new_data !== 1'b0) begin $display("FAIL rst_new_data: got %b want 0", tx_new_data); n_err++; end
        n_vec++; if (tx_char !== 8'h00) begin $display("FAIL rst_char: got %h want 00", tx_char); n_err++; end
        n_vec++; if (ack !== 4'b0000) begin $display("FAIL rst_ack: got %b want 0000", ack); n_err++; end
        n_vec++; if (busy !== 1'b0) begin $display("FAIL rst_busy: got %b want 0", busy); n_err++; end
        n_vec++; if (grant_id !== 2'd0) begin $display("FAIL rst_grant_id: got %0d want 0", grant_id); n_err++; end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int c_ack, t;
        data = 32'h000000B5; req = 4'b0001;
        tick();
        n_vec++; if (tx_new_data !== 1'b1) begin $display("FAIL single_new_data: got %b want 1", tx_new_data); n_err++; end
        n_vec++; if (tx_char !== 8'hB5) begin $display("FAIL single_char: got %h want b5", tx_char); n_err++; end
        n_vec++; if (busy !== 1'b1) begin $display("FAIL single_busy: got %b want 1", busy); n_err++; end
        n_vec++; if (ack !== 4'b0000) begin $display("FAIL single_ack_early: got %b want 0000", ack); n_err++; end
        tick();
        n_vec++; if (ack !== 4'b0001) begin $display("FAIL single_ack: got %b want 0001", ack); n_err++; end
        n_vec++; if (tx_new_data !== 1'b0) begin $display("FAIL single_new_data_clr: got %b want 0", tx_new_data); n_err++; end
        req = '0;
        c_ack = cyc;
        tick();
        n_vec++; if (ack !== 4'b0000) begin $display("FAIL single_ack_pulse: got %b want 0000", ack); n_err++; end
        t = 0;
        while (busy && t < 60) begin tick(); t++; end
        // 10 busy cycles from the model, then one edge for DRAIN to see tx_rdy.
        n_vec++; if (cyc - c_ack !== 11) begin $display("FAIL single_busy_fall: busy fell %0d cycles after ack, want 11", cyc - c_ack); n_err++; end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_id [5];
        logic [7:0] exp_byte [5];
        logic [7:0] bytes [4];
        int n_ack, c_last;
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
`ifdef UART_ARB_FIXED_PRIO_EN
        exp_id = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
        exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
        for (int i = 0; i < 5; i++) exp_byte[i] = bytes[exp_id[i]];
        do_reset();
        data = 32'h44332211; req = 4'b1111;
        n_ack = 0; c_last = 0;
        for (int t = 0; t < 120 && n_ack < 5; t++) begin
            tick();
            if (ack !== 4'b0000) begin
                n_vec++; if (grant_id !== exp_id[n_ack]) begin $display("FAIL rr_order%0d: got %0d want %0d", n_ack, grant_id, exp_id[n_ack]); n_err++; end
                n_vec++; if (ack !== (4'b0001 << exp_id[n_ack])) begin $display("FAIL rr_ack%0d: got %b want %b", n_ack, ack, 4'b0001 << exp_id[n_ack]); n_err++; end
                n_vec++; if (tx_char !== exp_byte[n_ack]) begin $display("FAIL rr_char%0d: got %h want %h", n_ack, tx_char, exp_byte[n_ack]); n_err++; end
                if (n_ack > 0) begin
                    n_vec++; if (cyc - c_last !== 13) begin $display("FAIL rr_spacing%0d: got %0d want 13", n_ack, cyc - c_last); n_err++; end
                end
                c_last = cyc;
                n_ack++;
            end
        end
        n_vec++; if (n_ack !== 5) begin $display("FAIL rr_ack_count: got %0d want 5", n_ack); n_err++; end
        req = '0;
        wait_idle("rr");
    endtask

    task automatic test_gap();
        int t_r, t_n, n_low, seen;
        logic prev_rdy, prev_nd;
        logic [1:0] gid;
        do_reset();
        g_data = 32'h0000BBAA; g_req = 4'b0011;
        t_r = -1; t_n = -1; n_low = 0; seen = 0; gid = '0;
        prev_rdy = g_tx_rdy; prev_nd = g_tx_new_data;
        for (int t = 0; t < 100 && t_n < 0; t++) begin
            tick();
            if (g_ack !== 4'b0000) begin g_req = g_req & ~g_ack; seen++; end
            if (seen == 1 && t_r < 0 && g_tx_rdy && !prev_rdy) t_r = cyc;
            if (t_r >= 0 && !g_busy) n_low++;
            if (t_r >= 0 && g_tx_new_data && !prev_nd) begin t_n = cyc; gid = g_grant_id; end
            prev_rdy = g_tx_rdy; prev_nd = g_tx_new_data;
        end
        // Zero-gap turnaround is 2 cycles (DRAIN->IDLE, IDLE->LOAD); GAP adds 3 bit-times.
        n_vec++; if (t_r < 0 || t_n - t_r !== 5) begin $display("FAIL gap_delay: got %0d want 5 (t_r=%0d)", t_n - t_r, t_r); n_err++; end
        n_vec++; if (gid !== 2'd1) begin $display("FAIL gap_second_id: got %0d want 1", gid); n_err++; end
        n_vec++; if (g_tx_char !== 8'hBB) begin $display("FAIL gap_second_char: got %h want bb", g_tx_char); n_err++; end
        n_vec++; if (n_low !== 1) begin $display("FAIL gap_busy_low: busy low %0d cycles, want 1", n_low); n_err++; end
        tick();
        n_vec++; if (g_ack !== 4'b0010) begin $display("FAIL gap_second_ack: got %b want 0010", g_ack); n_err++; end
        g_req = '0;
    endtask

    task automatic test_tx_not_ready();
        int bad;
        hold_low = 1'b1; tx_rdy = 1'b0;
        data = 32'h005C0000; req = 4'b0100;
        bad = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (tx_new_data !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0) bad++;
        end
        n_vec++; if (bad !== 0) begin $display("FAIL nrdy_hold: %0d cycles with activity, want 0", bad); n_err++; end
        hold_low = 1'b0; tx_rdy = 1'b1;
        tick();
        n_vec++; if (tx_new_data !== 1'b1 || grant_id !== 2'd2) begin $display("FAIL nrdy_grant: new_data=%b id=%0d want 1/2", tx_new_data, grant_id); n_err++; end
        n_vec++; if (tx_char !== 8'h5C) begin $display("FAIL nrdy_char: got %h want 5c", tx_char); n_err++; end
        tick();
        n_vec++; if (ack !== 4'b0100) begin $display("FAIL nrdy_ack: got %b want 0100", ack); n_err++; end
        req = '0;
        wait_idle("nrdy");
    endtask

    task automatic test_reset_mid_load();
        int bad;
        data = 32'h00007E00; req = 4'b0010;
        tick();
        hold_low = 1'b1; tx_rdy = 1'b0;
        tick(); tick();
        n_vec++; if (tx_new_data !== 1'b1) begin $display("FAIL mid_load_hold: got %b want 1", tx_new_data); n_err++; end
        rst_n = 1'b0;
        #1;
        n_vec++; if (tx_new_data !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0) begin $display("FAIL mid_async_clr: new_data=%b ack=%b busy=%b want 0/0000/0", tx_new_data, ack, busy); n_err++; end
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (tx_new_data !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_vec++; if (bad !== 0) begin $display("FAIL mid_no_grant: %0d cycles granted while tx_rdy=0, want 0", bad); n_err++; end
        hold_low = 1'b0; tx_rdy = 1'b1;
        tick();
        n_vec++; if (tx_new_data !== 1'b1 || grant_id !== 2'd1) begin $display("FAIL mid_regrant: new_data=%b id=%0d want 1/1", tx_new_data, grant_id); n_err++; end
        tick();
        n_vec++; if (ack !== 4'b0010) begin $display("FAIL mid_ack: got %b want 0010", ack); n_err++; end
        req = '0;
        wait_idle("mid");
    endtask

    task automatic test_drop_req();
        int n_ack, n_nd;
        data = 32'h00003C00; req = 4'b0010;
        tick();
        n_vec++; if (grant_id !== 2'd1 || tx_new_data !== 1'b1) begin $display("FAIL drop_grant: id=%0d new_data=%b want 1/1", grant_id, tx_new_data); n_err++; end
        req = '0; data = 32'h0000FF00;
        hold_low = 1'b1; tx_rdy = 1'b0;
        tick();
        n_vec++; if (tx_new_data !== 1'b1 || tx_char !== 8'h3C) begin $display("FAIL drop_committed: new_data=%b char=%h want 1/3c", tx_new_data, tx_char); n_err++; end
        hold_low = 1'b0; tx_rdy = 1'b1;
        n_ack = 0; n_nd = 0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (ack === 4'b0010) n_ack++;
            else if (ack !== 4'b0000) n_ack += 100;
            if (t > 0 && tx_new_data) n_nd++;
        end
        n_vec++; if (n_ack !== 1) begin $display("FAIL drop_ack_once: got %0d want 1", n_ack); n_err++; end
        n_vec++; if (n_nd !== 0) begin $display("FAIL drop_no_regrant: %0d load cycles, want 0", n_nd); n_err++; end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_gap();
        test_tx_not_ready();
        test_reset_mid_load();
        test_drop_req();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
